// File: rtl/mac_pkg.sv
// Shared types and defaults for the MAC serial front/back end.
//   mac_io_state_e : controller states of mac_serial_io
//   OP_W_DEF       : default operand width
//   RES_W_DEF      : default accumulator result width
//   FRAME_W        : serial result frame width (result plus carry)
package mac_pkg;

    localparam int unsigned OP_W_DEF  = 8;
    localparam int unsigned RES_W_DEF = 20;
    localparam int unsigned FRAME_W   = RES_W_DEF + 1;

    typedef enum logic [2:0] {
        StIdle,
        StShiftIn,
        StStart,
        StWaitFin,
        StShiftOut,
        StDone
    } mac_io_state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mac_serial_io_if.sv
// Pin/controller-side signals of mac_serial_io.
//   master : environment side (serial pins, MAC controller, result sink)
//   slave  : mac_serial_io itself
interface mac_serial_io_if import mac_pkg::*; #(
    parameter int unsigned OP_W  = OP_W_DEF,
    parameter int unsigned RES_W = RES_W_DEF
);
    logic             ser_a_in;
    logic             ser_b_in;
    logic             in_valid;
    logic [OP_W-1:0]  op_a;
    logic [OP_W-1:0]  op_b;
    logic             input_done;
    logic             start_out;
    logic             finish_in;
    logic [RES_W-1:0] mac_res_in;
    logic             mac_carry_in;
    logic             ser_out;
    logic             ser_out_valid;
    logic             ser_out_ready;
    logic             out_done;
    logic             timeout_err;
    logic             busy;

    modport master (
        output ser_a_in, ser_b_in, in_valid, finish_in, mac_res_in, mac_carry_in, ser_out_ready,
        input  op_a, op_b, input_done, start_out, ser_out, ser_out_valid, out_done,
               timeout_err, busy
    );

    modport slave (
        input  ser_a_in, ser_b_in, in_valid, finish_in, mac_res_in, mac_carry_in, ser_out_ready,
        output op_a, op_b, input_done, start_out, ser_out, ser_out_valid, out_done,
               timeout_err, busy
    );
endinterface

// File: rtl/mac_piso_shifter.sv
// Parallel-load, LSB-first shifter with bit counter.
//   load/load_data : capture a new frame, counter cleared
//   shift_en       : advance one bit (sink accepted ser_bit)
//   ser_bit        : current bit (shreg[0])
//   last           : current bit is the final bit of the frame
module mac_piso_shifter import mac_pkg::*; #(
    parameter int unsigned WIDTH = FRAME_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             shift_en,
    output logic             ser_bit,
    output logic             last
);
    localparam int unsigned CntW = cnt_width(WIDTH);

    logic [WIDTH-1:0] shreg_q;
    logic [CntW-1:0]  bcnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shreg_q <= '0;
            bcnt_q  <= '0;
        end else if (load) begin
            shreg_q <= load_data;
            bcnt_q  <= '0;
        end else if (shift_en) begin
            shreg_q <= {1'b0, shreg_q[WIDTH-1:1]};
            bcnt_q  <= bcnt_q + 1'b1;
        end
    end

    assign ser_bit = shreg_q[0];
    assign last    = (bcnt_q == CntW'(WIDTH - 1));

endmodule

// File: rtl/mac_serial_io.sv
// Bit-serial front/back end for the 8x8 MAC datapath.
//   clk, reset_n : clock, asynchronous active-low reset
//   io (slave)   : serial operand inputs (MSB first) -> op_a/op_b, input_done, start_out;
//                  finish_in rising edge captures {carry, result} and shifts it out
//                  LSB first on ser_out under ser_out_valid/ser_out_ready;
//                  out_done, timeout_err pulses; busy outside IDLE.
module mac_serial_io import mac_pkg::*; #(
    parameter int unsigned OP_W    = OP_W_DEF,
    parameter int unsigned RES_W   = RES_W_DEF,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          reset_n,
    mac_serial_io_if.slave io
);
    localparam int unsigned CntW  = cnt_width(OP_W);
    localparam int unsigned WcntW = cnt_width(TIMEOUT);
    localparam bit          TmoEn = (TIMEOUT != 0);

    mac_io_state_e   state_q;
    logic [OP_W-1:0] op_a_q;
    logic [OP_W-1:0] op_b_q;
    logic [CntW-1:0] cnt_q;
    logic [WcntW-1:0] wcnt_q;
    logic            finish_q;
    logic            start_q;
    logic            input_done_q;
    logic            out_done_q;
    logic            timeout_q;
    logic            valid_q;

    logic fin_edge;
    logic tmo_hit;
    logic sh_load;
    logic sh_shift;
    logic sh_bit;
    logic sh_last;

    // Only a fresh rising edge counts; finish_q is primed in START so a stale level is ignored.
    assign fin_edge = io.finish_in & ~finish_q;
    assign tmo_hit  = TmoEn && (wcnt_q == WcntW'(TIMEOUT - 1));
    assign sh_load  = (state_q == StWaitFin) && fin_edge;
    assign sh_shift = valid_q && io.ser_out_ready;

    mac_piso_shifter #(
        .WIDTH (RES_W + 1)
    ) u_piso (
        .clk       (clk),
        .reset_n   (reset_n),
        .load      (sh_load),
        .load_data ({io.mac_carry_in, io.mac_res_in}),
        .shift_en  (sh_shift),
        .ser_bit   (sh_bit),
        .last      (sh_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            op_a_q       <= '0;
            op_b_q       <= '0;
            cnt_q        <= '0;
            wcnt_q       <= '0;
            finish_q     <= 1'b0;
            start_q      <= 1'b0;
            input_done_q <= 1'b0;
            out_done_q   <= 1'b0;
            timeout_q    <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            start_q      <= 1'b0;
            input_done_q <= 1'b0;
            out_done_q   <= 1'b0;
            timeout_q    <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (io.in_valid) begin
                        op_a_q  <= {op_a_q[OP_W-2:0], io.ser_a_in};
                        op_b_q  <= {op_b_q[OP_W-2:0], io.ser_b_in};
                        cnt_q   <= CntW'(1);
                        state_q <= StShiftIn;
                    end
                end
                StShiftIn: begin
                    if (io.in_valid) begin
                        op_a_q <= {op_a_q[OP_W-2:0], io.ser_a_in};
                        op_b_q <= {op_b_q[OP_W-2:0], io.ser_b_in};
                        if (cnt_q == CntW'(OP_W - 1)) begin
                            cnt_q   <= '0;
                            state_q <= StStart;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                StStart: begin
                    start_q      <= 1'b1;
                    input_done_q <= 1'b1;
                    finish_q     <= io.finish_in;
                    wcnt_q       <= '0;
                    state_q      <= StWaitFin;
                end
                StWaitFin: begin
                    finish_q <= io.finish_in;
                    if (fin_edge) begin
                        valid_q <= 1'b1;
                        state_q <= StShiftOut;
                    end else if (tmo_hit) begin
                        timeout_q <= 1'b1;
                        state_q   <= StIdle;
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                StShiftOut: begin
                    if (io.ser_out_ready && sh_last) begin
                        valid_q    <= 1'b0;
                        out_done_q <= 1'b1;
                        state_q    <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign io.op_a          = op_a_q;
    assign io.op_b          = op_b_q;
    assign io.input_done    = input_done_q;
    assign io.start_out     = start_q;
    assign io.ser_out       = valid_q & sh_bit;
    assign io.ser_out_valid = valid_q;
    assign io.out_done      = out_done_q;
    assign io.timeout_err   = timeout_q;
    assign io.busy          = (state_q != StIdle);

endmodule

// File: tb/tb_mac_serial_io.sv
module tb_mac_serial_io;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        int         cyc;
    } op_exp_t;

    logic clk = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;

    op_exp_t op_q[$];
    logic    bit_q[$];
    int      done_q[$];
    int      tmo_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mac_serial_io_if #(.OP_W(8), .RES_W(20)) io ();

    mac_serial_io #(
        .OP_W    (8),
        .RES_W   (20),
        .TIMEOUT (16)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .io      (io)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Scoreboard side: every DUT pulse/bit pops what the stimulus pushed.
    always @(negedge clk) begin
        if (reset_n) begin
            if (io.start_out) begin
                check("start_expected", 32'(op_q.size() > 0), 32'd1);
                if (op_q.size() > 0) begin
                    op_exp_t e;
                    e = op_q.pop_front();
                    check("op_a", 32'(io.op_a), 32'(e.a));
                    check("op_b", 32'(io.op_b), 32'(e.b));
                    check("input_done", 32'(io.input_done), 32'd1);
                    check("start_cycle", cyc, e.cyc);
                end
            end else if (io.input_done) begin
                check("input_done_alone", 32'(io.start_out), 32'd1);
            end
            if (io.ser_out_valid) begin
                check("valid_expected", 32'(bit_q.size() > 0), 32'd1);
                if (io.ser_out_ready && bit_q.size() > 0)
                    check("ser_bit", 32'(io.ser_out), 32'(bit_q.pop_front()));
            end
            if (io.out_done) begin
                check("done_expected", 32'(done_q.size() > 0), 32'd1);
                if (done_q.size() > 0) check("done_cycle", cyc, done_q.pop_front());
                check("done_valid_low", 32'(io.ser_out_valid), 32'd0);
            end
            if (io.timeout_err) begin
                check("tmo_expected", 32'(tmo_q.size() > 0), 32'd1);
                if (tmo_q.size() > 0) check("tmo_cycle", cyc, tmo_q.pop_front());
                check("tmo_busy", 32'(io.busy), 32'd0);
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_op_a"}, 32'(io.op_a), 32'd0);
        check({tag, "_op_b"}, 32'(io.op_b), 32'd0);
        check({tag, "_outs"}, 32'({io.input_done, io.start_out, io.ser_out, io.ser_out_valid,
                                   io.out_done, io.timeout_err, io.busy}), 32'd0);
    endtask

    // Gap of 'gap' idle cycles after bits 2 and 5; returns expected start_out cycle.
    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input int gap,
                              output int start_cyc);
        int first;
        op_exp_t e;
        first = 0;
        start_cyc = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                first = cyc;
                start_cyc = first + 7 + 2 * gap + 2;
            end
            io.in_valid = 1'b1;
            io.ser_a_in = a[7-i];
            io.ser_b_in = b[7-i];
            if (i == 7) begin
                e.a = a;
                e.b = b;
                e.cyc = start_cyc;
                op_q.push_back(e);
            end
            if (i == 1 || i == 4) begin
                for (int g = 0; g < gap; g++) begin
                    @(posedge clk); #1;
                    io.in_valid = 1'b0;
                    io.ser_a_in = 1'($urandom);
                    io.ser_b_in = 1'($urandom);
                end
            end
        end
        @(posedge clk); #1;
        io.in_valid = 1'b0;
        io.ser_a_in = 1'($urandom);
        io.ser_b_in = 1'($urandom);
    endtask

    task automatic run_result(input logic [19:0] res, input logic c, input int stall_at,
                              input int stall_len);
        logic [20:0] frame;
        int f;
        frame = {c, res};
        @(posedge clk); #1;
        io.mac_res_in   = res;
        io.mac_carry_in = c;
        io.finish_in    = 1'b1;
        f = cyc;
        for (int i = 0; i < 21; i++) bit_q.push_back(frame[i]);
        done_q.push_back(f + 22 + stall_len);
        @(negedge clk);
        check("pre_edge_valid", 32'(io.ser_out_valid), 32'd0);
        @(posedge clk); #1;
        io.mac_res_in   = ~res;
        io.mac_carry_in = ~c;
        @(negedge clk);
        check("first_valid", 32'(io.ser_out_valid), 32'd1);
        if (stall_len > 0) begin
            repeat (stall_at) @(posedge clk);
            #1;
            io.ser_out_ready = 1'b0;
            for (int j = 0; j < stall_len; j++) begin
                @(negedge clk);
                check("stall_bit", 32'(io.ser_out), 32'(frame[stall_at]));
                check("stall_valid", 32'(io.ser_out_valid), 32'd1);
                @(posedge clk); #1;
            end
            io.ser_out_ready = 1'b1;
        end
        repeat (28) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int sc;
        logic [7:0] part;
        reset_n = 1'b0;
        io.ser_a_in = 1'b0;
        io.ser_b_in = 1'b0;
        io.in_valid = 1'b0;
        io.finish_in = 1'b0;
        io.mac_res_in = '0;
        io.mac_carry_in = 1'b0;
        io.ser_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        @(posedge clk); #1;
        check_all_zero("post_reset");

        // Continuous frame, then result with sink always ready.
        send_frame(8'hA5, 8'h3C, 0, sc);
        repeat (3) @(posedge clk);
        run_result(20'h12345, 1'b1, 0, 0);
        io.finish_in = 1'b0;

        // Gapped frame, then result with a 4-cycle stall at bit 7; finish stays high.
        send_frame(8'hA5, 8'h3C, 3, sc);
        repeat (3) @(posedge clk);
        run_result(20'h12345, 1'b1, 7, 4);

        // Stale finish level: no edge, must time out and keep operands.
        send_frame(8'h0F, 8'hF0, 0, sc);
        tmo_q.push_back(sc + 16);
        repeat (25) @(posedge clk);
        #1;
        check("tmo_keep_a", 32'(io.op_a), 32'h0F);
        check("tmo_keep_b", 32'(io.op_b), 32'hF0);
        check("tmo_idle", 32'(io.busy), 32'd0);
        io.finish_in = 1'b0;

        // Reset in the middle of a frame.
        part = 8'hD6;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            io.in_valid = 1'b1;
            io.ser_a_in = part[7-i];
            io.ser_b_in = ~part[7-i];
        end
        @(posedge clk); #3;
        io.in_valid = 1'b0;
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(posedge clk); #1;
        reset_n = 1'b1;

        send_frame(8'h5A, 8'hC3, 0, sc);
        repeat (3) @(posedge clk);
        run_result(20'($urandom), 1'($urandom), 0, 0);
        io.finish_in = 1'b0;
        repeat (5) @(posedge clk);
        #1;

        check("op_q_left", 32'(op_q.size()), 32'd0);
        check("bit_q_left", 32'(bit_q.size()), 32'd0);
        check("done_q_left", 32'(done_q.size()), 32'd0);
        check("tmo_q_left", 32'(tmo_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mac_serial_io.md
Name: mac_serial_io

Overview:
Bit-serial front/back end for the 8x8 MAC datapath.
- Upstream side: deserializes operand A and operand B from two serial pins into parallel words, then issues a one-cycle start request to the MAC controller.
- Downstream side: on the controller's finish indication, captures the 20-bit accumulated result plus carry and shifts it out on a single pin under a ready/valid handshake.
- Sits between the chip pins and the MAC controller/register/accumulator stages.

Parameters:
OP_W, 8, operand width in bits.
RES_W, 20, accumulator result width in bits; the serial frame is RES_W+1 bits including carry.
TIMEOUT, 1024, max cycles in WAIT_FIN before abort; 0 disables the timeout.

Ports:
clk  input  1  clock; all state updates on rising edge.
reset_n  input  1  asynchronous, active-low reset.
ser_a_in  input  1  operand A serial bit, MSB first.
ser_b_in  input  1  operand B serial bit, MSB first.
in_valid  input  1  ser_a_in/ser_b_in carry a valid bit this cycle.
op_a  output  OP_W  assembled operand A to the operand register.
op_b  output  OP_W  assembled operand B to the operand register.
input_done  output  1  one-cycle pulse: both operands complete.
start_out  output  1  one-cycle start request to the MAC controller.
finish_in  input  1  controller finish level.
mac_res_in  input  RES_W  accumulator result.
mac_carry_in  input  1  accumulator carry out.
ser_out  output  1  result serial bit, LSB first, carry last.
ser_out_valid  output  1  ser_out is valid.
ser_out_ready  input  1  sink accepts ser_out this cycle.
out_done  output  1  one-cycle pulse after the last bit is accepted.
timeout_err  output  1  one-cycle pulse on a WAIT_FIN timeout.
busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - State returns to IDLE.
  - op_a, op_b, and the result shift register clear to 0.
  - The bit counter and timeout counter clear to 0.
  - Every 1-bit output is 0.
- States are IDLE, SHIFT_IN, START, WAIT_FIN, SHIFT_OUT, DONE.
- IDLE:
  - If in_valid=1: op_a <= {op_a[OP_W-2:0], ser_a_in}, op_b likewise, cnt <= 1, go to SHIFT_IN.
- SHIFT_IN:
  - Each in_valid=1 cycle shifts one bit into op_a/op_b and increments cnt.
  - in_valid=0 holds all state; gaps of any length are legal.
  - On the cycle that accepts bit OP_W (cnt==OP_W-1 with in_valid=1), next state is START and input_done pulses in the following cycle.
- START:
  - Hold for exactly one cycle with start_out=1 and input_done=1.
  - Capture finish_q <= finish_in.
  - Go to WAIT_FIN.
- WAIT_FIN:
  - Wait for a rising edge: finish_in=1 while finish_q=0, with finish_q updated every cycle. A stale finish level from the previous operation does not trigger.
  - On the edge, load shreg <= {mac_carry_in, mac_res_in}, set bcnt <= 0, go to SHIFT_OUT.
  - If TIMEOUT!=0 and the wait counter reaches TIMEOUT-1, pulse timeout_err, go to IDLE, and keep op_a/op_b.
- SHIFT_OUT:
  - ser_out=shreg[0], ser_out_valid=1.
  - When ser_out_ready=1, shreg shifts right by 1 and bcnt increments.
  - ser_out_ready=0 stalls with ser_out stable.
  - Bit order: result bit 0 first, result bit RES_W-1, then carry as bit RES_W.
  - When bit RES_W is accepted, go to DONE.
- DONE:
  - One cycle with out_done=1 and ser_out_valid=0, then go to IDLE.
- in_valid is ignored in every state except IDLE and SHIFT_IN. It is not buffered.
- op_a/op_b hold their last assembled values until the next frame begins shifting.
- Latency:
  - start_out is 2 cycles after the last input bit is accepted.
  - The first result bit is valid 1 cycle after the finish edge.
  - With ser_out_ready tied to 1, out_done is RES_W+2 cycles after the finish edge.
- An asynchronous reset mid-frame discards the partial operands and any in-flight result without emitting a pulse.

Decomposition:
- Package mac_pkg holds:
  - the state enum typedef mac_io_state_e;
  - localparams OP_W_DEF=8, RES_W_DEF=20, FRAME_W=RES_W+1.
- One sub-module, mac_piso_shifter, is natural: a parallel-load, ready-gated, LSB-first shifter with a bit counter and last-bit flag. It handles the result serialization.
- The deserializer stays inline.

Test Plan:
- Shift A=0xA5, B=0x3C MSB first with in_valid continuous -> op_a=0xA5, op_b=0x3C; input_done and start_out pulse once, 2 cycles after bit 8.
- Same operands with in_valid gaps of 3 cycles after bits 2 and 5 -> identical values; pulses are delayed by exactly 6 cycles.
- Raise finish_in with mac_res_in=0x12345, mac_carry_in=1, ser_out_ready=1 -> ser_out sequence 1,0,1,0,0,0,1,0,1,1,0,0,0,1,0,0,1,0,0,0 then 1; out_done 22 cycles after the edge.
- Drop ser_out_ready for 4 cycles at bit 7 -> ser_out holds bit 7 and ser_out_valid=1; the frame completes 4 cycles later with the same bit sequence.
- Hold finish_in=1 from a previous operation into WAIT_FIN, with TIMEOUT=16 and no new edge -> no shift-out; timeout_err pulses 16 cycles after START, then IDLE with busy=0.
- Assert reset_n=0 after 4 input bits, then release -> all outputs 0, and a fresh 8-bit frame produces correct operands.
